// File: rtl/counter_arb_if.sv
// Request/grant bundle between the clients and the ticket-dispensing arbiter.
// The master side drives requests and clear; the slave side returns the grant and ticket.
interface counter_arb_if #(
    parameter int Requesters = 4
);
    logic [Requesters-1:0] Req_i;
    logic                  Clear_i;
    logic [Requesters-1:0] Grant_o;
    logic                  Valid_o;
    logic [31:0]           Data_o;
    logic                  Full_o;

    modport master (
        output Req_i,
        output Clear_i,
        input  Grant_o,
        input  Valid_o,
        input  Data_o,
        input  Full_o
    );

    modport slave (
        input  Req_i,
        input  Clear_i,
        output Grant_o,
        output Valid_o,
        output Data_o,
        output Full_o
    );
endinterface

// File: rtl/counter_arb.sv
// Round-robin arbiter dispensing strictly increasing tickets Init..Limit from one
// shared saturating counter; one grant at most every two cycles, sync clear restarts.
module counter_arb #(
    parameter logic [31:0] Init       = 32'd8,
    parameter logic [31:0] Limit      = 32'd64,
    parameter int          Requesters = 4
) (
    input  logic          Clk_i,
    input  logic          Reset_n_i,
    counter_arb_if.slave  bus
);
    localparam int LW = (Requesters > 1) ? $clog2(Requesters) : 1;

    generate
        if ((Limit < Init) || (Limit == 32'hFFFF_FFFF) || (Requesters < 2) || (Requesters > 16)) begin : g_bad_param
            $error("counter_arb: illegal Init/Limit/Requesters combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EXHAUSTED
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           count_q, count_d;
    logic [LW-1:0]         last_q, last_d;
    logic [Requesters-1:0] grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic [31:0]           data_q, data_d;
    logic                  full_q, full_d;

    logic                  pick_vld;
    logic [LW-1:0]         pick_idx;
    logic [Requesters-1:0] pick_oh;
    logic [LW-1:0]         cand;

    // Search upward from the client after the last winner, wrapping modulo Requesters.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        cand     = '0;
        for (int k = 1; k <= Requesters; k++) begin
            cand = LW'((int'(last_q) + k) % Requesters);
            if (!pick_vld && bus.Req_i[cand]) begin
                pick_vld      = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        grant_d = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        full_d  = full_q;
        case (state_q)
            IDLE: begin
                if (bus.Clear_i) begin
                    count_d = Init;
                end else if (pick_vld) begin
                    grant_d = pick_oh;
                    valid_d = 1'b1;
                    data_d  = count_q;
                    last_d  = pick_idx;
                    if (count_q == Limit) begin
                        state_d = EXHAUSTED;
                        full_d  = 1'b1;
                    end else begin
                        state_d = GRANT;
                        count_d = 32'(count_q + 32'd1);
                    end
                end
            end
            GRANT: begin
                // Requests are deliberately not sampled here so clients can drop Req_i.
                state_d = IDLE;
                if (bus.Clear_i) begin
                    count_d = Init;
                end
            end
            EXHAUSTED: begin
                if (bus.Clear_i) begin
                    count_d = Init;
                    full_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= IDLE;
            count_q <= Init;
            last_q  <= LW'(Requesters - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            full_q  <= full_d;
        end
    end

    assign bus.Grant_o = grant_q;
    assign bus.Valid_o = valid_q;
    assign bus.Data_o  = data_q;
    assign bus.Full_o  = full_q;
endmodule

// File: doc/counter_arb.md
# counter_arb

Round-robin arbiter that shares one saturating sequence counter between `Requesters` clients, dispensing unique, strictly increasing tickets from `Init` to `Limit`. Each grant hands exactly one counter value to exactly one requester, then advances the counter. The block sits between the request sources and the shared counter datapath: it owns the counter register, its sequencing and its exhaustion state. A synchronous clear restarts the sequence.

## Interface
- `Init`, 8: first value dispensed after reset or clear.
- `Limit`, 64: last value dispensed; requires `Init <= Limit < 2^32-1` (elaboration-time check).
- `Requesters`, 4: number of clients, 2..16.

- `Clk_i`  in  1  single clock; all state updates on the rising edge.
- `Reset_n_i`  in  1  reset, asynchronous and active-low.
- `Req_i`  in  Requesters  level request per client; held high until the matching `Grant_o` bit is seen.
- `Clear_i`  in  1  synchronous restart of the sequence at `Init`.
- `Grant_o`  out  Requesters  one-hot grant, registered, one-cycle pulse.
- `Valid_o`  out  1  high exactly when `Grant_o` is non-zero.
- `Data_o`  out  32  ticket value belonging to the current grant; holds the last dispensed value otherwise.
- `Full_o`  out  1  sequence exhausted (`Limit` dispensed); no further grants until clear.

## Operation
- Internal state: counter `Count` (32 bit), round-robin pointer `Last` (index of last granted client), FSM.
- FSM states: `IDLE`, `GRANT`, `EXHAUSTED`.
- `IDLE`: if `Clear_i`, then stay in `IDLE` with `Count <= Init`. Else if any `Req_i` bit is set, pick the first set bit searching upward from `Last+1` modulo `Requesters`. Then register `Grant_o` one-hot for the winner, `Valid_o <= 1`, `Data_o <= Count`, `Last <= winner`, and go to `GRANT`. If `Count == Limit`, go to `EXHAUSTED` instead of `GRANT`. Otherwise `Count <= Count + 1`.
- `GRANT`: the grant outputs are visible for this cycle only. Next state is `IDLE`, with `Grant_o` and `Valid_o` cleared. Requests are not sampled in this state, which gives clients one cycle to drop `Req_i`. `Clear_i` here sets `Count <= Init` and goes to `IDLE`.
- `EXHAUSTED`: `Full_o = 1`, requests are ignored, and `Grant_o`/`Valid_o` clear after the final grant cycle. `Clear_i` sets `Count <= Init`, `Full_o <= 0`, and goes to `IDLE`.
- `Clear_i` always has priority over a same-cycle request. No grant is issued in the cycle `Clear_i` is sampled.
- `Clear_i` does not alter `Last` and does not alter `Data_o`.
- Arithmetic: `Count` never exceeds `Limit` and never wraps. Dispensed values are strictly increasing by 1 between clears.
- Fairness: with all clients requesting continuously, grants rotate 0,1,2,…,Requesters-1,0,…

## Timing
- Reset (async assert, sync release) values: `Grant_o = 0`, `Valid_o = 0`, `Data_o = 0`, `Full_o = 0`, `Count = Init`, `Last = Requesters-1` (client 0 wins first), state `IDLE`.
- Latency: when `Req_i` is sampled high in `IDLE` at edge N, `Grant_o`/`Data_o` are valid during cycle N..N+1.
- Throughput: at most one grant per 2 cycles.
- `Full_o` rises in the same cycle as the grant carrying `Limit` and stays high until the edge after `Clear_i`.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The interrupted ticket is lost.
- A requester that keeps `Req_i` high after its grant is treated as a new request on the next `IDLE` cycle.

## Test plan
- Reset then single client: `Req_i = 4'b0001` held 1 cycle. Required: `Grant_o = 0001`, `Data_o = 8`, `Valid_o = 1` one cycle later, for one cycle only. The next ticket is 9.
- All four clients continuously requesting, from reset: grants alternate with idle cycles in order 0,1,2,3,0. `Data_o` reads 8,9,10,11,12. `Valid_o` is never high two consecutive cycles.
- Exhaustion with `Init = 62`, `Limit = 64`, one client requesting: tickets 62,63,64. `Full_o = 1` with the 64 grant. Further requests get no grant. `Clear_i` then lowers `Full_o`, and the next grant carries 62.
- `Clear_i` and `Req_i` asserted in the same `IDLE` cycle after tickets 8..10: no grant in that cycle. The next grant carries 8. The round-robin order continues from `Last`.
- Async reset asserted in a `GRANT` cycle: `Grant_o`, `Valid_o` and `Data_o` read 0 before the next edge. After release, the first grant goes to client 0 with value 8.
- Invariants checked formally every cycle:
  - `Grant_o` is one-hot or zero, and `Valid_o == |Grant_o`.
  - The granted bit was set in `Req_i` one cycle earlier.
  - `Init <= Data_o <= Limit` whenever `Valid_o`.
